debounce_multi: RTL and testbench

//  Multi-channel switch-input conditioner: synchronises, debounces and edge-classifies NUM_CHANNELS raw inputs.

---
 rtl/debounce_pkg.sv | 22 ++
 rtl/debounce_multi_if.sv | 34 +++
 rtl/debounce_channel.sv | 92 +++++++++
 rtl/debounce_multi.sv | 75 +++++++
 tb/tb_debounce_multi.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Provides the counter sizing function and the per-channel state record.
package debounce_pkg;

    // Wide enough for any supported filter or hold limit (up to 65535).
    localparam int CNT_W = 16;

    typedef struct packed {
        logic             level;
        logic [CNT_W-1:0] filter_cnt;
        logic [CNT_W-1:0] hold_cnt;
    } channel_state_t;

    // Bits needed to hold values 0..max; never less than one bit.
    function automatic int counter_width(input int max);
        if (max < 1) begin
            return 1;
        end
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Pin-side and user-side signal bundle of the multi-channel debouncer.
// master: drives sampling_trigger/async_in, observes the conditioned outputs.
// slave:  the debouncer itself.
interface debounce_multi_if #(
    parameter int NUM_CHANNELS = 4
);
    logic                    sampling_trigger;
    logic [NUM_CHANNELS-1:0] async_in;
    logic [NUM_CHANNELS-1:0] level_out;
    logic [NUM_CHANNELS-1:0] press_pulse;
    logic [NUM_CHANNELS-1:0] release_pulse;
    logic [NUM_CHANNELS-1:0] long_press_pulse;
    logic                    tick_out;

    modport master (
        output sampling_trigger,
        output async_in,
        input  level_out,
        input  press_pulse,
        input  release_pulse,
        input  long_press_pulse,
        input  tick_out
    );

    modport slave (
        input  sampling_trigger,
        input  async_in,
        output level_out,
        output press_pulse,
        output release_pulse,
        output long_press_pulse,
        output tick_out
    );
endinterface

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser chain, tick-driven glitch filter,
// hold counter and registered press/release/long-press pulses.
// Ports: clock, reset (sync, active-high), tick, async_in -> level_out,
//        press_pulse, release_pulse, long_press_pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNCHRONIZE_FF_DEPTH = 2,
    parameter int FILTER_COUNTER_MAX   = 3,
    parameter int LONG_PRESS_SAMPLES   = 500,
    parameter int ACTIVE_LOW           = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic async_in,
    output logic level_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);
    localparam logic AL      = (ACTIVE_LOW != 0);
    localparam logic HOLD_EN = (LONG_PRESS_SAMPLES != 0);
    localparam logic [CNT_W-1:0] FMAX = CNT_W'(FILTER_COUNTER_MAX);
    localparam logic [CNT_W-1:0] HMAX = CNT_W'(LONG_PRESS_SAMPLES);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [SYNCHRONIZE_FF_DEPTH-1:0] sync_q;
    logic                            s;
    channel_state_t                  st_q;
    channel_state_t                  st_d;
    logic                            press_d;
    logic                            release_d;
    logic                            long_d;

    // Sync flops rest at the pin's idle level so reset looks "not pressed".
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= {SYNCHRONIZE_FF_DEPTH{AL}};
        end else begin
            sync_q <= {sync_q[SYNCHRONIZE_FF_DEPTH-2:0], async_in};
        end
    end

    assign s = sync_q[SYNCHRONIZE_FF_DEPTH-1] ^ AL;

    always_comb begin
        st_d      = st_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        if (tick) begin
            if (s != st_q.level) begin
                if (st_q.filter_cnt == FMAX) begin
                    st_d.level      = s;
                    st_d.filter_cnt = '0;
                    press_d         = s;
                    release_d       = ~s;
                end else begin
                    st_d.filter_cnt = st_q.filter_cnt + ONE;
                end
            end else begin
                st_d.filter_cnt = '0;
            end
            // Uses the pre-tick level, so the press tick itself is not counted.
            if (HOLD_EN && st_q.level && (st_q.hold_cnt != HMAX)) begin
                st_d.hold_cnt = st_q.hold_cnt + ONE;
                long_d        = (st_q.hold_cnt == HMAX - ONE);
            end
            if (!st_d.level) begin
                st_d.hold_cnt = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q             <= '0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            st_q             <= st_d;
            press_pulse      <= press_d;
            release_pulse    <= release_d;
            long_press_pulse <= long_d;
        end
    end

    assign level_out = st_q.level;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch conditioner: shared sampling tick plus N channels.
// Ports: clock, reset (sync, active-high), bus (debounce_multi_if.slave).
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int NUM_CHANNELS         = 4,
    parameter int SYNCHRONIZE_FF_DEPTH = 2,
    parameter int FILTER_COUNTER_MAX   = 3,
    parameter int SAMPLE_DIVIDER       = 1000,
    parameter int LONG_PRESS_SAMPLES   = 500,
    parameter int ACTIVE_LOW           = 0
) (
    input  logic             clock,
    input  logic             reset,
    debounce_multi_if.slave  bus
);
    logic                    tick_raw;
    logic                    tick;
    logic [NUM_CHANNELS-1:0] level_v;
    logic [NUM_CHANNELS-1:0] press_v;
    logic [NUM_CHANNELS-1:0] release_v;
    logic [NUM_CHANNELS-1:0] long_v;

    if (SAMPLE_DIVIDER == 0) begin : g_ext_tick
        assign tick_raw = bus.sampling_trigger;
    end else begin : g_int_tick
        localparam int PW = counter_width(SAMPLE_DIVIDER - 1);
        localparam logic [PW-1:0] PLAST = PW'(SAMPLE_DIVIDER - 1);

        logic [PW-1:0] pre_q;
        logic          unused_trigger;

        assign unused_trigger = bus.sampling_trigger;

        always_ff @(posedge clock) begin
            if (reset) begin
                pre_q <= '0;
            end else if (pre_q == PLAST) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
        end

        assign tick_raw = (pre_q == PLAST);
    end

    // Held low in reset so tick_out reads 0 like every other output.
    assign tick = tick_raw & ~reset;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNCHRONIZE_FF_DEPTH (SYNCHRONIZE_FF_DEPTH),
            .FILTER_COUNTER_MAX   (FILTER_COUNTER_MAX),
            .LONG_PRESS_SAMPLES   (LONG_PRESS_SAMPLES),
            .ACTIVE_LOW           (ACTIVE_LOW)
        ) u_ch (
            .clock            (clock),
            .reset            (reset),
            .tick             (tick),
            .async_in         (bus.async_in[i]),
            .level_out        (level_v[i]),
            .press_pulse      (press_v[i]),
            .release_pulse    (release_v[i]),
            .long_press_pulse (long_v[i])
        );
    end

    assign bus.level_out        = level_v;
    assign bus.press_pulse      = press_v;
    assign bus.release_pulse    = release_v;
    assign bus.long_press_pulse = long_v;
    assign bus.tick_out         = tick;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: three instances cover the internal
// tick (active-high and active-low pins) and the external trigger.
module tb_debounce_multi;

    logic clock;
    logic reset;
    int   now;
    int   checks;
    int   failures;

    debounce_multi_if #(.NUM_CHANNELS(4)) ifa ();
    debounce_multi_if #(.NUM_CHANNELS(4)) ifb ();
    debounce_multi_if #(.NUM_CHANNELS(4)) ifc ();

    debounce_multi #(
        .NUM_CHANNELS(4), .SYNCHRONIZE_FF_DEPTH(2),
        .FILTER_COUNTER_MAX(3), .SAMPLE_DIVIDER(4),
        .LONG_PRESS_SAMPLES(5), .ACTIVE_LOW(0)
    ) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));

    debounce_multi #(
        .NUM_CHANNELS(4), .SYNCHRONIZE_FF_DEPTH(2),
        .FILTER_COUNTER_MAX(3), .SAMPLE_DIVIDER(4),
        .LONG_PRESS_SAMPLES(5), .ACTIVE_LOW(1)
    ) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

    debounce_multi #(
        .NUM_CHANNELS(4), .SYNCHRONIZE_FF_DEPTH(2),
        .FILTER_COUNTER_MAX(3), .SAMPLE_DIVIDER(0),
        .LONG_PRESS_SAMPLES(0), .ACTIVE_LOW(0)
    ) dut_c (.clock(clock), .reset(reset), .bus(ifc.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to posedge k; external trigger is high in cycles k%3==2.
    task automatic go(input int k);
        while (now < k) begin
            @(posedge clock);
            #1;
            now++;
            ifc.sampling_trigger = (now % 3 == 2);
        end
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] lv,
                           input logic [3:0] pr, input logic [3:0] rl,
                           input logic [3:0] lp);
        check({tag, ".a_level"}, 32'(ifa.level_out), 32'(lv));
        check({tag, ".a_press"}, 32'(ifa.press_pulse), 32'(pr));
        check({tag, ".a_rel"}, 32'(ifa.release_pulse), 32'(rl));
        check({tag, ".a_long"}, 32'(ifa.long_press_pulse), 32'(lp));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        now      = -3;
        reset    = 1'b1;
        ifa.async_in = 4'h0;
        ifb.async_in = 4'hF;
        ifc.async_in = 4'h0;
        ifa.sampling_trigger = 1'b0;
        ifb.sampling_trigger = 1'b0;
        ifc.sampling_trigger = 1'b0;

        go(0);
        check_a("rst", 4'h0, 4'h0, 4'h0, 4'h0);
        check("rst.a_tick", 32'(ifa.tick_out), 32'd0);
        check("rst.b_level", 32'(ifb.level_out), 32'd0);
        check("rst.c_level", 32'(ifc.level_out), 32'd0);
        reset = 1'b0;
        // ch0/ch2 held, ch1 a 3-tick glitch; C ch0 held.
        ifa.async_in = 4'b0111;
        ifc.async_in = 4'b0001;

        go(2);
        check("p2.a_tick", 32'(ifa.tick_out), 32'd0);
        check("p2.c_tick", 32'(ifc.tick_out), 32'd1);
        go(3);
        check("p3.a_tick", 32'(ifa.tick_out), 32'd1);
        check("p3.c_tick", 32'(ifc.tick_out), 32'd0);
        go(4);
        check("p4.a_tick", 32'(ifa.tick_out), 32'd0);

        go(11);
        check("p11.c_level", 32'(ifc.level_out), 32'd0);
        go(12);
        check("p12.c_level", 32'(ifc.level_out), 32'd1);
        check("p12.c_press", 32'(ifc.press_pulse), 32'd1);
        ifa.async_in = 4'b0101;
        go(13);
        check("p13.c_press", 32'(ifc.press_pulse), 32'd0);

        go(15);
        check_a("p15", 4'h0, 4'h0, 4'h0, 4'h0);
        go(16);
        check_a("p16", 4'b0101, 4'b0101, 4'h0, 4'h0);
        check("p16.b_level", 32'(ifb.level_out), 32'd0);
        ifa.async_in = 4'b0111;
        ifb.async_in = 4'b0111;
        go(17);
        check_a("p17", 4'b0101, 4'h0, 4'h0, 4'h0);

        go(20);
        check_a("p20", 4'b0101, 4'h0, 4'h0, 4'h0);
        go(31);
        check_a("p31", 4'b0101, 4'h0, 4'h0, 4'h0);
        check("p31.b_level", 32'(ifb.level_out), 32'd0);
        go(32);
        check_a("p32", 4'b0111, 4'b0010, 4'h0, 4'h0);
        check("p32.b_level", 32'(ifb.level_out), 32'h8);
        check("p32.b_press", 32'(ifb.press_pulse), 32'h8);

        go(35);
        check_a("p35", 4'b0111, 4'h0, 4'h0, 4'h0);
        go(36);
        check_a("p36", 4'b0111, 4'h0, 4'h0, 4'b0101);
        check("p36.c_long", 32'(ifc.long_press_pulse), 32'd0);
        ifa.async_in = 4'b0010;
        go(37);
        check_a("p37", 4'b0111, 4'h0, 4'h0, 4'h0);
        go(40);
        check_a("p40", 4'b0111, 4'h0, 4'h0, 4'h0);
        go(44);
        check_a("p44", 4'b0111, 4'h0, 4'h0, 4'h0);

        go(51);
        check_a("p51", 4'b0111, 4'h0, 4'h0, 4'h0);
        go(52);
        check_a("p52", 4'b0010, 4'h0, 4'b0101, 4'b0010);
        check("p52.b_long", 32'(ifb.long_press_pulse), 32'h8);
        ifa.async_in = 4'b0011;
        go(53);
        check_a("p53", 4'b0010, 4'h0, 4'h0, 4'h0);

        // ch0 mid-count and ch1 pressed when reset hits.
        go(60);
        reset = 1'b1;
        go(61);
        check_a("p61", 4'h0, 4'h0, 4'h0, 4'h0);
        check("p61.a_tick", 32'(ifa.tick_out), 32'd0);
        check("p61.b_level", 32'(ifb.level_out), 32'd0);
        check("p61.b_rel", 32'(ifb.release_pulse), 32'd0);
        check("p61.c_level", 32'(ifc.level_out), 32'd0);
        go(62);
        reset = 1'b0;

        go(64);
        check("p64.a_tick", 32'(ifa.tick_out), 32'd0);
        go(65);
        check("p65.a_tick", 32'(ifa.tick_out), 32'd1);
        go(66);
        check("p66.a_tick", 32'(ifa.tick_out), 32'd0);
        go(77);
        check_a("p77", 4'h0, 4'h0, 4'h0, 4'h0);
        check("p77.b_level", 32'(ifb.level_out), 32'd0);
        go(78);
        check_a("p78", 4'b0011, 4'b0011, 4'h0, 4'h0);
        check("p78.b_level", 32'(ifb.level_out), 32'h8);
        check("p78.b_press", 32'(ifb.press_pulse), 32'h8);

        go(82);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
